// File: rtl/issue_pkg.sv
// Shared types and sizing for the issue stage and its in-flight load FIFO.
package issue_pkg;

    localparam int LD_DEPTH_DEF = 2;

    function automatic int ld_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int LD_CNT_W = ld_cnt_w(LD_DEPTH_DEF);

    typedef struct packed {
        logic        valid;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic        rf_we;
        logic        load;
    } issue_reg_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       rf_we;
    } ld_ent_t;

    localparam int LD_ENT_W = $bits(ld_ent_t);

endpackage

// File: rtl/ld_fifo.sv
// Small synchronous FIFO; a pop on empty is ignored, a push on full only lands
// when a pop frees the head slot in the same cycle.
module ld_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 6,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             push_ok, pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop_ok)
                rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// Issue register plus load-use scoreboard between decode and execute/LSU.
// Optional macro ISSUE_CTRL_LD_BYPASS_EN lets a completing load release its consumer the same cycle.
module issue_ctrl
    import issue_pkg::*;
#(
    parameter int LD_DEPTH = LD_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [4:0]                    i_rs1_addr,
    input  logic [4:0]                    i_rs2_addr,
    input  logic                          i_rs1_re,
    input  logic                          i_rs2_re,
    input  logic [4:0]                    i_rd,
    input  logic                          i_rf_we,
    input  logic                          i_lsu_load,
    input  logic [31:0]                   i_insn,
    output logic                          o_issue_valid,
    input  logic                          i_issue_ready,
    output logic [31:0]                   o_issue_insn,
    output logic [4:0]                    o_issue_rd,
    output logic                          o_issue_load,
    input  logic                          i_ld_done,
    input  logic                          i_flush,
    output logic [ld_cnt_w(LD_DEPTH)-1:0] o_ld_pending
);

    localparam int CNT_W = ld_cnt_w(LD_DEPTH);

    issue_reg_t       q, d;
    logic [31:0]      busy_q, busy_d, busy_eff, set_vec, clr_vec;
    ld_ent_t          head, push_ent;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_cnt;
    logic             iss, push, pop, accept;
    logic             held_ld_hit, hazard, full_stall;

    // Flush wins over the execute handshake, so a flushed load never enters the FIFO.
    assign iss      = q.valid & i_issue_ready & ~i_flush;
    assign push     = iss & q.load;
    assign pop      = i_ld_done & ~fifo_empty;
    assign push_ent = '{rd: q.rd, rf_we: q.rf_we};

    ld_fifo #(
        .DEPTH (LD_DEPTH),
        .WIDTH (LD_ENT_W)
    ) u_ld_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_ent),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (push && q.rf_we && q.rd != '0)
            set_vec[q.rd] = 1'b1;
        if (pop && head.rf_we && head.rd != '0)
            clr_vec[head.rd] = 1'b1;
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
    end

`ifdef ISSUE_CTRL_LD_BYPASS_EN
    assign busy_eff   = busy_q & ~clr_vec;
    assign full_stall = i_lsu_load & fifo_full & ~i_ld_done;
`else
    assign busy_eff   = busy_q;
    assign full_stall = i_lsu_load & fifo_full;
`endif

    // A load sitting in the issue register is not yet in the scoreboard, so match it directly.
    assign held_ld_hit = q.valid & q.load & q.rf_we & (q.rd != '0);

    always_comb begin
        hazard = 1'b0;
        if (i_rs1_re && (busy_eff[i_rs1_addr] || (held_ld_hit && i_rs1_addr == q.rd)))
            hazard = 1'b1;
        if (i_rs2_re && (busy_eff[i_rs2_addr] || (held_ld_hit && i_rs2_addr == q.rd)))
            hazard = 1'b1;
        if (i_rf_we && (busy_eff[i_rd] || (held_ld_hit && i_rd == q.rd)))
            hazard = 1'b1;
    end

    assign o_ready = (~q.valid | i_issue_ready) & ~hazard & ~full_stall & ~i_flush;
    assign accept  = i_valid & o_ready;

    always_comb begin
        d = q;
        if (i_flush)
            d.valid = 1'b0;
        else if (accept)
            d = '{valid: 1'b1, insn: i_insn, rd: i_rd, rf_we: i_rf_we, load: i_lsu_load};
        else if (iss)
            d.valid = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= '0;
            busy_q <= '0;
        end else begin
            q      <= d;
            busy_q <= busy_d;
        end
    end

    assign o_issue_valid = q.valid;
    assign o_issue_insn  = q.insn;
    assign o_issue_rd    = q.rd;
    assign o_issue_load  = q.load;
    assign o_ld_pending  = fifo_cnt;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed test-plan steps followed by random traffic, checked against a queue-based issue model.
module tb_issue_ctrl;
    import issue_pkg::*;

    localparam int D = 2;
`ifdef ISSUE_CTRL_LD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk, rst_n;
    logic i_valid, o_ready, i_rs1_re, i_rs2_re, i_rf_we, i_lsu_load;
    logic [4:0] i_rs1_addr, i_rs2_addr, i_rd, o_issue_rd;
    logic [31:0] i_insn, o_issue_insn;
    logic o_issue_valid, i_issue_ready, o_issue_load, i_ld_done, i_flush;
    logic [ld_cnt_w(D)-1:0] o_ld_pending;

    issue_ctrl #(.LD_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rs1_re(i_rs1_re), .i_rs2_re(i_rs2_re),
        .i_rd(i_rd), .i_rf_we(i_rf_we), .i_lsu_load(i_lsu_load), .i_insn(i_insn),
        .o_issue_valid(o_issue_valid), .i_issue_ready(i_issue_ready), .o_issue_insn(o_issue_insn),
        .o_issue_rd(o_issue_rd), .o_issue_load(o_issue_load), .i_ld_done(i_ld_done),
        .i_flush(i_flush), .o_ld_pending(o_ld_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: held instruction, in-order queue of outstanding loads (rd*2+we), busy flags.
    bit        m_valid, m_we, m_ld;
    bit [31:0] m_insn;
    bit [4:0]  m_rd;
    int        ldq[$];
    bit        m_busy[32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_valid = 0; m_we = 0; m_ld = 0; m_insn = '0; m_rd = '0;
        ldq.delete();
        foreach (m_busy[i]) m_busy[i] = 0;
    endfunction

    function automatic bit reg_busy(input bit [4:0] r, input int clr);
        return (r != 0) && m_busy[r] && !(BYP && int'(r) == clr);
    endfunction

    function automatic bit dep(input bit en, input bit [4:0] r, input int clr);
        bit held = m_valid && m_ld && m_we && (m_rd != 0);
        return en && (reg_busy(r, clr) || (held && r == m_rd));
    endfunction

    function automatic bit model_ready();
        int clr = -1;
        bit haz, fstall;
        if (i_ld_done && ldq.size() > 0 && ldq[0] % 2 == 1 && ldq[0] / 2 != 0)
            clr = ldq[0] / 2;
        haz = dep(i_rs1_re, i_rs1_addr, clr) || dep(i_rs2_re, i_rs2_addr, clr) ||
              dep(i_rf_we, i_rd, clr);
        fstall = i_lsu_load && ldq.size() == D && !(BYP && i_ld_done);
        return (!m_valid || i_issue_ready) && !haz && !fstall && !i_flush;
    endfunction

    function automatic void model_clock(input bit rdy);
        bit iss = m_valid && i_issue_ready && !i_flush;
        if (i_ld_done && ldq.size() > 0) begin
            int e = ldq.pop_front();
            if (e % 2 == 1 && e / 2 != 0) m_busy[e / 2] = 0;
        end
        if (iss && m_ld) begin
            ldq.push_back(m_rd * 2 + m_we);
            if (m_we && m_rd != 0) m_busy[m_rd] = 1;
        end
        if (i_flush) m_valid = 0;
        else if (i_valid && rdy) begin
            m_valid = 1; m_insn = i_insn; m_rd = i_rd; m_we = i_rf_we; m_ld = i_lsu_load;
        end else if (iss) m_valid = 0;
    endfunction

    task automatic put(input bit v, input bit [4:0] rs1, input bit re1, input bit [4:0] rs2,
                       input bit re2, input bit [4:0] rd, input bit we, input bit ld,
                       input bit [31:0] insn, input bit ir, input bit done, input bit fl);
        i_valid = v; i_rs1_addr = rs1; i_rs1_re = re1; i_rs2_addr = rs2; i_rs2_re = re2;
        i_rd = rd; i_rf_we = we; i_lsu_load = ld; i_insn = insn;
        i_issue_ready = ir; i_ld_done = done; i_flush = fl;
    endtask

    // One clock: check o_ready mid-cycle, advance the model on the edge, check registered outputs.
    task automatic step(output bit obs_rdy);
        bit er;
        @(negedge clk);
        er = model_ready();
        obs_rdy = o_ready;
        chk("ready", o_ready, er);
        @(posedge clk);
        model_clock(er);
        #1;
        chk("issue_valid", o_issue_valid, m_valid);
        chk("issue_insn", o_issue_insn, m_insn);
        chk("issue_rd", o_issue_rd, m_rd);
        chk("issue_load", o_issue_load, m_ld);
        chk("ld_pending", o_ld_pending, ldq.size());
    endtask

    task automatic idle(input int n);
        bit r;
        for (int i = 0; i < n; i++) begin
            put(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            step(r);
        end
    endtask

    initial begin
        bit r;
        int acc_k;
        rst_n = 0;
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", o_issue_valid, 0);
        chk("rst_insn", o_issue_insn, 0);
        chk("rst_pending", o_ld_pending, 0);
        chk("rst_ready", o_ready, 1);
        i_flush = 1; #1;
        chk("rst_ready_flush", o_ready, 0);
        i_flush = 0;
        @(negedge clk);
        rst_n = 1;

        // Back-to-back independent ADDIs
        for (int k = 1; k <= 3; k++) begin
            put(1, 0, 1, 0, 0, 5'(k), 1, 0, 32'h100 + k, 1, 0, 0);
            step(r);
            chk("addi_ready", r, 1);
            chk("addi_valid", o_issue_valid, 1);
        end
        idle(1);

        // Load-use: LD x5 then ADD x6,x5,x7, completion three cycles after the load issues
        put(1, 2, 1, 0, 0, 5, 1, 1, 32'h200, 1, 0, 0);
        step(r);
        acc_k = -1;
        for (int k = 0; k < 7 && acc_k < 0; k++) begin
            put(1, 5, 1, 7, 1, 6, 1, 0, 32'h201, 1, k == 3, 0);
            step(r);
            if (r) acc_k = k;
        end
        chk("ldu_accept_cycle", acc_k, BYP ? 3 : 4);
        idle(2);

        // FIFO-full stall with two outstanding loads
        put(1, 0, 0, 0, 0, 8, 1, 1, 32'h300, 1, 0, 0); step(r);
        put(1, 0, 0, 0, 0, 9, 1, 1, 32'h301, 1, 0, 0); step(r);
        idle(1);
        chk("full_pending2", o_ld_pending, 2);
        acc_k = -1;
        for (int k = 0; k < 5 && acc_k < 0; k++) begin
            put(1, 0, 0, 0, 0, 10, 1, 1, 32'h302, 1, k == 1, 0);
            step(r);
            if (r) acc_k = k;
        end
        chk("full_accept_cycle", acc_k, BYP ? 1 : 2);
        chk("full_pending1", o_ld_pending, 1);
        for (int k = 0; k < 4 && ldq.size() > 0; k++) begin
            put(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
            step(r);
        end
        idle(1);
        chk("drained", o_ld_pending, 0);

        // Flush of a held load: no push, its consumer issues right after
        put(1, 0, 0, 0, 0, 10, 1, 1, 32'h400, 0, 0, 0); step(r);
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1); step(r);
        chk("flush_valid", o_issue_valid, 0);
        chk("flush_nopush", o_ld_pending, 0);
        put(1, 10, 1, 0, 0, 11, 1, 0, 32'h401, 1, 0, 0); step(r);
        chk("flush_consumer_ready", r, 1);
        idle(1);

        // Load to x0 marks nothing busy
        put(1, 0, 0, 0, 0, 0, 1, 1, 32'h500, 1, 0, 0); step(r);
        put(1, 0, 1, 0, 1, 1, 1, 0, 32'h501, 1, 0, 0); step(r);
        chk("x0_consumer_ready", r, 1);
        idle(2);
        chk("x0_pending", o_ld_pending, 1);
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); step(r);
        chk("x0_pending_done", o_ld_pending, 0);

        // Execute back-pressure then release
        put(1, 0, 0, 0, 0, 12, 1, 0, 32'h600, 1, 0, 0); step(r);
        for (int k = 0; k < 4; k++) begin
            put(1, 0, 0, 0, 0, 13, 1, 0, 32'h601, 0, 0, 0); step(r);
            chk("bp_ready", r, 0);
            chk("bp_insn", o_issue_insn, 32'h600);
        end
        put(1, 0, 0, 0, 0, 13, 1, 0, 32'h601, 1, 0, 0); step(r);
        chk("bp_release_ready", r, 1);
        chk("bp_release_insn", o_issue_insn, 32'h601);

        // Stray completion with nothing outstanding
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); step(r);
        chk("empty_done", o_ld_pending, 0);

        // Random traffic; loads are only offered while the FIFO cannot be overrun
        for (int n = 0; n < 800; n++) begin
            bit v, ld, held;
            v    = ($urandom % 4) != 0;
            ld   = ($urandom % 3) == 0;
            held = m_valid && m_ld;
            if (v && ld && !(ldq.size() == D || ldq.size() + held < D)) ld = 0;
            put(v, 5'($urandom % 8), 1'($urandom), 5'($urandom % 8), 1'($urandom),
                5'($urandom % 8), 1'($urandom), ld, $urandom, ($urandom % 4) != 0,
                ldq.size() > 0 ? ($urandom % 3) == 0 : ($urandom % 20) == 0,
                ($urandom % 16) == 0);
            step(r);
        end

        // Asynchronous reset mid-operation drops outstanding loads at once
        put(1, 0, 0, 0, 0, 14, 1, 1, 32'h700, 1, 0, 0); step(r);
        idle(2);
        @(negedge clk); #2;
        rst_n = 0; #1;
        chk("mid_rst_pending", o_ld_pending, 0);
        chk("mid_rst_valid", o_issue_valid, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        put(1, 14, 1, 0, 0, 15, 1, 0, 32'h701, 1, 0, 0); step(r);
        chk("post_rst_ready", r, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
